data_mem_responder: RTL and testbench

Responder side of the single-cycle core's data-memory port. Decodes each access, serves word RAM and a small memory-mapped I/O page, and supplies read data combinationally in the same cycle so the core's single-cycle load path is met. The I/O page holds a free-running cycle counter and an output FIFO. The FIFO drains to an external consumer over a valid/ready stream.

---
 rtl/mem_map_pkg.sv | 17 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/data_mem_responder.sv | 114 +++++++++++
 tb/tb_data_mem_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared constants for the data-memory responder.
//   - I/O page word offsets (relative to IO_BASE, compared against Addr[15:0])
//   - STATUS register bit positions
//   - default base address of the I/O page
package mem_map_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [15:0] CYCLE_OFS  = 16'h0000;
    localparam logic [15:0] TXDATA_OFS = 16'h0004;
    localparam logic [15:0] STATUS_OFS = 16'h0008;

    localparam int OVF_BIT   = 31;
    localparam int FULL_BIT  = 30;
    localparam int EMPTY_BIT = 29;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (control state only)
//   push, din : write request and data; accepted when not full or when a pop
//               happens in the same cycle
//   pop       : read request; ignored while empty
//   dout      : head entry, forced to 0 while empty
//   count     : number of stored entries (log2(DEPTH)+1 bits)
//   full      : count == DEPTH
//   empty     : count == 0
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !rd_en)      count <= count + CW'(1);
            else if (rd_en && !wr_en) count <= count - CW'(1);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder for a single-cycle core.
// Serves a word RAM (aliased modulo DEPTH_WORDS) and a small I/O page at
// IO_BASE holding a free-running cycle counter, an output FIFO push port and
// a status register. Read data is combinational so loads complete in-cycle.
// Ports:
//   CLK, reset          : clock, asynchronous active-high reset
//   MemWrite            : store strobe, sampled on the rising edge
//   Addr, WriteData     : byte address and store data
//   ReadData            : combinational read data for Addr
//   OutData, OutValid   : FIFO head and non-empty flag (valid/ready stream)
//   OutReady            : consumer accept
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] OutData,
    output logic        OutValid,
    input  logic        OutReady
);

    localparam int RAW = $clog2(DEPTH_WORDS);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]    ram [DEPTH_WORDS];
    logic [RAW-1:0] ram_idx;
    logic           is_io;
    logic [15:0]    ofs;
    logic [31:0]    cycle_cnt;
    logic           overflow;
    logic           cyc_wr;
    logic           tx_wr;
    logic           stat_wr;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [31:0]    status_word;

    assign is_io   = (Addr[31:16] == IO_BASE[31:16]);
    assign ofs     = Addr[15:0];
    assign ram_idx = Addr[RAW+1:2];

    assign cyc_wr  = MemWrite && is_io && (ofs == CYCLE_OFS);
    assign tx_wr   = MemWrite && is_io && (ofs == TXDATA_OFS);
    assign stat_wr = MemWrite && is_io && (ofs == STATUS_OFS);

    assign fifo_pop = OutValid && OutReady;

    sync_fifo #(
        .DATA_W (32),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (reset),
        .push  (tx_wr),
        .pop   (fifo_pop),
        .din   (WriteData),
        .dout  (OutData),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign OutValid = !fifo_empty;

    // RAM contents survive reset; only non-I/O stores land here.
    always_ff @(posedge CLK) begin
        if (MemWrite && !is_io) ram[ram_idx] <= WriteData;
    end

    // A load replaces the increment for that cycle.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)       cycle_cnt <= '0;
        else if (cyc_wr) cycle_cnt <= WriteData;
        else             cycle_cnt <= cycle_cnt + 32'd1;
    end

    // A dropped push (full, no simultaneous pop) sets the sticky flag; any
    // STATUS write clears it. The two cannot coincide since they use
    // different offsets.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)                                 overflow <= 1'b0;
        else if (tx_wr && fifo_full && !fifo_pop)  overflow <= 1'b1;
        else if (stat_wr)                          overflow <= 1'b0;
    end

    always_comb begin
        status_word            = '0;
        status_word[OVF_BIT]   = overflow;
        status_word[FULL_BIT]  = fifo_full;
        status_word[EMPTY_BIT] = fifo_empty;
        status_word[15:0]      = {{(16-CW){1'b0}}, fifo_count};
    end

    always_comb begin
        ReadData = '0;
        if (is_io) begin
            if (ofs == CYCLE_OFS)       ReadData = cycle_cnt;
            else if (ofs == STATUS_OFS) ReadData = status_word;
        end else begin
            ReadData = ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: RAM, cycle counter, output FIFO
// stream and asynchronous reset behaviour against hand-computed values.
module tb_data_mem_responder;

    localparam int          DEPTH_WORDS = 64;
    localparam int          FIFO_DEPTH  = 8;
    localparam logic [31:0] IO          = 32'hFFFF_0000;

    logic        CLK = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] OutData;
    logic        OutValid;
    logic        OutReady;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .IO_BASE     (IO)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .OutData   (OutData),
        .OutValid  (OutValid),
        .OutReady  (OutReady)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr      = a;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(tag, ReadData, exp);
    endtask

    logic [31:0] exp_q [8];

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        Addr      = 32'h0;
        WriteData = 32'h0;
        OutReady  = 1'b0;

        // Reset state
        #3;
        rd("status_in_reset", IO + 32'h8, 32'h2000_0000);
        check("outvalid_in_reset", {31'b0, OutValid}, 32'h0);
        check("outdata_in_reset", OutData, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        rd("cycle_after_5", IO + 32'h0, 32'd5);

        // RAM write, alias, I/O isolation
        wr(32'h10, 32'hDEAD_BEEF);
        rd("ram_read", 32'h10, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h10 + 4 * DEPTH_WORDS, 32'hDEAD_BEEF);
        wr(IO + 32'h10, 32'h1111_1111);
        rd("io_unmapped_read", IO + 32'h10, 32'h0);
        rd("ram_after_io_wr", 32'h10, 32'hDEAD_BEEF);
        rd("txdata_reads_zero", IO + 32'h4, 32'h0);

        // Fill FIFO, overflow, drain
        for (int i = 1; i <= 8; i++) wr(IO + 32'h4, i);
        rd("status_full", IO + 32'h8, 32'h4000_0008);
        check("head_held", OutData, 32'd1);
        wr(IO + 32'h4, 32'd9);
        rd("status_ovf", IO + 32'h8, 32'hC000_0008);
        OutReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_valid", {31'b0, OutValid}, 32'h1);
            check("drain_data", OutData, i);
            tick();
        end
        check("drain_done_valid", {31'b0, OutValid}, 32'h0);
        rd("status_empty_ovf", IO + 32'h8, 32'hA000_0000);
        wr(IO + 32'h8, 32'h0);
        rd("status_ovf_clear", IO + 32'h8, 32'h2000_0000);

        // Simultaneous push/pop at full
        OutReady = 1'b0;
        for (int i = 0; i < 8; i++) wr(IO + 32'h4, 32'h10 + i);
        OutReady = 1'b1;
        wr(IO + 32'h4, 32'hAA);
        OutReady = 1'b0;
        rd("status_pushpop_full", IO + 32'h8, 32'h4000_0008);
        for (int i = 0; i < 7; i++) exp_q[i] = 32'h11 + i;
        exp_q[7] = 32'hAA;
        OutReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("pp_drain_data", OutData, exp_q[i]);
            tick();
        end
        check("pp_drain_empty", {31'b0, OutValid}, 32'h0);

        // Simultaneous push/pop at count=1
        OutReady = 1'b0;
        wr(IO + 32'h4, 32'h55);
        OutReady = 1'b1;
        wr(IO + 32'h4, 32'h66);
        OutReady = 1'b0;
        check("pp_one_data", OutData, 32'h66);
        rd("pp_one_status", IO + 32'h8, 32'h0000_0001);
        OutReady = 1'b1;
        tick();
        check("pp_one_drained", {31'b0, OutValid}, 32'h0);
        OutReady = 1'b0;

        // Cycle counter load and wrap
        wr(IO + 32'h0, 32'hFFFF_FFFE);
        rd("cycle_load", IO + 32'h0, 32'hFFFF_FFFE);
        tick();
        rd("cycle_max", IO + 32'h0, 32'hFFFF_FFFF);
        tick();
        rd("cycle_wrap", IO + 32'h0, 32'h0);

        // Async reset mid-stream
        for (int i = 0; i < 3; i++) wr(IO + 32'h4, 32'h100 + i);
        rd("pre_reset_count", IO + 32'h8, 32'h0000_0003);
        check("pre_reset_valid", {31'b0, OutValid}, 32'h1);
        reset = 1'b1;
        #1;
        check("async_valid_drop", {31'b0, OutValid}, 32'h0);
        check("async_data_zero", OutData, 32'h0);
        tick();
        reset = 1'b0;
        rd("post_reset_status", IO + 32'h8, 32'h2000_0000);
        rd("post_reset_cycle", IO + 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
